noc_mem_endpoint: RTL
=====================

// Module: noc_mem_endpoint
// PURPOSE
//  Memory-side sink attached to one output of the last NOC crossbar layer. Consumes
//  {addr,data} write flits (FIFO_ENQ_downstream/FIFO_OUT) and returns full_o as that
//  output's FIFO_FULL_downstream. Buffers flits, checks the routing bits against its own
//  ID, drops misrouted flits and drives a ready-handshaked write port into the local bank.
// PARAMETERS
//  ADDR_WIDTH     16  flit address width (flit MSBs)
//  DATA_WIDTH     32  flit data width (flit LSBs)
//  RADIX_OUT      8   crossbar output radix per layer
//  NETWORK_DEPTH  1   crossbar layers; ROUTE_BITS = $clog2(RADIX_OUT)*NETWORK_DEPTH
//  DEPTH          2   ingress FIFO entries (>=2)
//  ENDPOINT_ID    0   expected value of addr[ADDR_WIDTH-1 -: ROUTE_BITS]
// PORTS
//  clk            in   1                      clock
//  rst_l          in   1                      asynchronous reset, active-low
//  flit_enq_i     in   1                      flit valid from crossbar
//  flit_i         in   ADDR_WIDTH+DATA_WIDTH  {addr,data}
//  full_o         out  1                      ingress FIFO full; upstream must not enqueue
//  mem_we_o       out  1                      write valid to bank
//  mem_addr_o     out  ADDR_WIDTH-ROUTE_BITS  local word address = addr[ADDR_WIDTH-ROUTE_BITS-1:0]
//  mem_wdata_o    out  DATA_WIDTH             write data
//  mem_ready_i    in   1                      bank accepts write when mem_we_o && mem_ready_i
//  clr_err_i      in   1                      synchronous clear of sticky error flags
//  misroute_err_o out  1                      sticky: flit with wrong route ID dropped
//  overflow_err_o out  1                      sticky: enqueue while full, flit dropped
//  wr_count_o     out  32                     accepted bank writes (stats)
//  drop_count_o   out  32                     dropped flits, misroute+overflow (stats)
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, output stage IDLE; rst_l mid-operation discards
//    buffered and pending flits with no bank write.
//  - Ingress: circular FIFO with count 0..DEPTH. full_o = (count==DEPTH), registered state
//    only, no path from flit_enq_i (prevents a loop with the upstream arbiter).
//  - flit_enq_i while full_o: flit dropped, overflow_err_o=1 next edge, even if a pop happens
//    in the same cycle. Enqueue and pop in one cycle: count unchanged.
//  - Head check (combinational on head): match = head route bits == ENDPOINT_ID.
//    Mismatching head is popped in that cycle, never written, misroute_err_o=1 next edge.
//  - Output stage FSM: IDLE (mem_we_o=0) / WRITE (mem_we_o=1; addr/data held from output
//    register, stable until accepted).
//      load = fifo_nonempty && match && (IDLE || (WRITE && mem_ready_i)).
//      load pops head into output register and goes to WRITE.
//      WRITE && mem_ready_i && !load -> IDLE.
//  - Latency: enq at edge N -> mem_we_o high after edge N+1. With mem_ready_i held high,
//    throughput is 1 flit/cycle. Order is preserved.
//  - Misroute drop and load cannot both occur in one cycle (single head).
//  - clr_err_i clears both sticky flags at the next edge; a new error in the same cycle wins.
// CONFIGURATION
//  NOC_EP_STATS_EN defined:
//    wr_count_o +1 per mem_we_o&&mem_ready_i.
//    drop_count_o +1 per misroute or overflow drop; +2 if both occur in one cycle.
//    Both counters saturate at 32'hFFFF_FFFF, reset to 0, not cleared by clr_err_i.
//  NOC_EP_STATS_EN undefined: no counter flops; both ports tied to 0.
// TESTING (ADDR_WIDTH=16, DATA_WIDTH=32, RADIX_OUT=8, NETWORK_DEPTH=1, DEPTH=2, ENDPOINT_ID=3)
//  1 Assert rst_l=0 mid-stream -> all outputs 0, full_o=0, no mem_we_o after release until
//    a new enqueue.
//  2 Enq {16'h6012,32'hDEADBEEF}, mem_ready_i=1 -> mem_we_o=1 one cycle after the next
//    edge, mem_addr_o=13'h0012, mem_wdata_o=32'hDEADBEEF; wr_count_o=1 (STATS_EN).
//  3 mem_ready_i=0, enq 3 valid flits A,B,C -> A held on bank port, full_o=1 after C.
//    Enq D while full -> overflow_err_o=1, drop_count_o=1.
//    Then mem_ready_i=1 -> A,B,C accepted on 3 consecutive cycles, D never appears.
//  4 Enq addr 16'hE000 (route 7) -> no mem_we_o, misroute_err_o=1, drop_count_o=1.
//    Pulse clr_err_i -> flag 0, counter stays 1.
//  5 count=1, mem_ready_i=1, enq every cycle for 8 cycles -> full_o stays 0,
//    8 writes in order, no errors.
//  6 Build without NOC_EP_STATS_EN, repeat 3 -> counters read 0, data path identical.

Source files
------------

// File: rtl/noc_mem_endpoint.sv
// Memory-side NOC sink: ingress FIFO, route-ID check, ready-handshaked bank write port.
// Define NOC_EP_STATS_EN to build the saturating write/drop statistics counters.
module noc_mem_endpoint #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int RADIX_OUT     = 8,
    parameter int NETWORK_DEPTH = 1,
    parameter int DEPTH         = 2,
    parameter int ENDPOINT_ID   = 0,
    localparam int ROUTE_BITS   = $clog2(RADIX_OUT) * NETWORK_DEPTH,
    localparam int LADDR_W      = ADDR_WIDTH - ROUTE_BITS
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  logic                         flit_enq_i,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] flit_i,
    output logic                         full_o,
    output logic                         mem_we_o,
    output logic [LADDR_W-1:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0]        mem_wdata_o,
    input  logic                         mem_ready_i,
    input  logic                         clr_err_i,
    output logic                         misroute_err_o,
    output logic                         overflow_err_o,
    output logic [31:0]                  wr_count_o,
    output logic [31:0]                  drop_count_o
);
    localparam int FLIT_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, WRITE} state_e;

    state_e                state_q, state_d;
    logic [FLIT_W-1:0]     fifo_mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [LADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mis_err_q, mis_err_d, ovf_err_q, ovf_err_d;

    logic [FLIT_W-1:0] head;
    logic nonempty, full, match, push, overflow, misroute, accept, load, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head     = fifo_mem[rd_ptr_q];
    assign nonempty = (count_q != '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign match    = (head[FLIT_W-1 -: ROUTE_BITS] == ROUTE_BITS'(ENDPOINT_ID));
    // full is registered state only, so enqueue while full drops even if a pop happens now
    assign push     = flit_enq_i && !full;
    assign overflow = flit_enq_i && full;
    assign misroute = nonempty && !match;
    assign accept   = (state_q == WRITE) && mem_ready_i;
    assign load     = nonempty && match && ((state_q == IDLE) || mem_ready_i);
    assign pop      = misroute || load;

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (load) begin
            state_d = WRITE;
            addr_d  = head[DATA_WIDTH +: LADDR_W];
            wdata_d = head[DATA_WIDTH-1:0];
        end else if (accept) begin
            state_d = IDLE;
        end
        // A fresh error in the clearing cycle still sets the flag
        mis_err_d = misroute || (mis_err_q && !clr_err_i);
        ovf_err_d = overflow || (ovf_err_q && !clr_err_i);
    end

    // NOTE: FIFO storage is not reset; count/pointers gate every read, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= flit_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mis_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mis_err_q <= mis_err_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    assign full_o         = full;
    assign mem_we_o       = (state_q == WRITE);
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign misroute_err_o = mis_err_q;
    assign overflow_err_o = ovf_err_q;

`ifdef NOC_EP_STATS_EN
    logic [31:0] wr_cnt_q, drop_cnt_q;
    logic [1:0]  drop_inc;

    assign drop_inc = 2'(misroute) + 2'(overflow);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (accept && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 1'b1;
            if (drop_cnt_q > (32'hFFFF_FFFF - 32'(drop_inc))) drop_cnt_q <= '1;
            else drop_cnt_q <= drop_cnt_q + 32'(drop_inc);
        end
    end

    assign wr_count_o   = wr_cnt_q;
    assign drop_count_o = drop_cnt_q;
`else
    assign wr_count_o   = '0;
    assign drop_count_o = '0;
`endif

endmodule
